// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue to a combinational ALU, settle-timed capture, valid/ready result.
// Define ALU_SEQ_ZFLAG_EN to add the registered res_zero flag.
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    input  logic [2:0]               cmd_s,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_s,
    input  logic [7:0]               alu_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_y,
    output logic [2:0]               res_s,
    output logic                     busy,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic                     res_zero,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;
    state_t          state_q, state_d;
    logic [10:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic [CW-1:0]   sc_q, sc_d;
    logic [3:0]      alu_a_q, alu_b_q;
    logic [2:0]      alu_s_q, res_s_q;
    logic [7:0]      res_y_q;
    logic            res_valid_q, res_valid_d, busy_q;
    logic            push, pop, cap;
    logic [10:0]     head;
    assign cmd_ready  = cnt_q != (AW+1)'(DEPTH);
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem_q[rd_q];
    assign fifo_count = cnt_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s      = alu_s_q;
    assign res_valid  = res_valid_q;
    assign res_y      = res_y_q;
    assign res_s      = res_s_q;
    assign busy       = busy_q;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd_a, cmd_b, cmd_s};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;
        cap         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sc_q == '0) begin
                    cap         = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    sc_d = sc_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    pop         = cnt_q != '0;
                    state_d     = cnt_q != '0 ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) sc_d = CW'(SETTLE - 1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sc_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            res_y_q     <= '0;
            res_s_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            res_valid_q <= res_valid_d;
            busy_q      <= state_d != ST_IDLE;
            if (pop) {alu_a_q, alu_b_q, alu_s_q} <= head;
            if (cap) begin
                res_y_q <= alu_y;
                res_s_q <= alu_s_q;
            end
        end
    end
`ifdef ALU_SEQ_ZFLAG_EN
    logic res_zero_q;
    assign res_zero = res_zero_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_zero_q <= 1'b0;
        else if (cap) res_zero_q <= alu_y == 8'h00;
    end
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench; two instances (SETTLE=1 and SETTLE=3) with ALU stubs y={a,b}.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n, cmd_valid, cmd_valid3, res_ready, res_ready3;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_s;
    logic       cmd_ready, res_valid, busy;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s, res_s;
    logic [7:0] res_y;
    logic [2:0] fifo_count;
    logic       cmd_ready3, res_valid3, busy3;
    logic [3:0] alu_a3, alu_b3;
    logic [2:0] alu_s3, res_s3;
    logic [7:0] res_y3;
    logic [2:0] fifo_count3;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       res_zero, res_zero3;
`endif
    alu_cmd_sequencer #(.DEPTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y({alu_a, alu_b}),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_s(res_s),
        .busy(busy),
`ifdef ALU_SEQ_ZFLAG_EN
        .res_zero(res_zero),
`endif
        .fifo_count(fifo_count)
    );
    alu_cmd_sequencer #(.DEPTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3), .alu_y({alu_a3, alu_b3}),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_y(res_y3), .res_s(res_s3),
        .busy(busy3),
`ifdef ALU_SEQ_ZFLAG_EN
        .res_zero(res_zero3),
`endif
        .fifo_count(fifo_count3)
    );
    int vectors = 0, miscompares = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    logic [10:0] sb[$];
    logic [10:0] e;
    int  cyc = 0, last_hs = 0;
    bit  gap_en = 1'b0, prev_en = 1'b0;
    always @(posedge clk) cyc++;
    // Handshake completes at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 0, 1);
            else begin
                e = sb.pop_front();
                chk("res_y", res_y, e[10:3]);
                chk("res_s", res_s, e[2:0]);
`ifdef ALU_SEQ_ZFLAG_EN
                chk("res_zero", res_zero, e[10:3] == 8'h00);
`endif
            end
            if (gap_en && prev_en) chk("gap", cyc - last_hs, 2);
            prev_en = gap_en;
            last_hs = cyc;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push_try(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, output bit acc);
        cmd_a = a; cmd_b = b; cmd_s = s; cmd_valid = 1'b1;
        acc = cmd_ready;
        if (acc) sb.push_back({a, b, s});
        tick();
        cmd_valid = 1'b0;
    endtask
    task automatic push_wait(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) push_try(a, b, s, acc);
        if (!acc) chk("push_timeout", 0, 1);
    endtask
    task automatic wait_drain;
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        chk("drain", sb.size(), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        bit acc;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0;
        res_ready = 1'b0; res_ready3 = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_s = '0;
        repeat (3) tick();
        chk("rst_alu_a", alu_a, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        // single command, SETTLE=1
        push_try(4'h9, 4'h3, 3'd0, acc);
        chk("t1_count", fifo_count, 1);
        chk("t1_alu_a_early", alu_a, 0);
        chk("t1_busy_early", busy, 0);
        tick();
        chk("t1_alu", {alu_a, alu_b, 1'b0, alu_s}, {4'h9, 4'h3, 1'b0, 3'd0});
        chk("t1_busy_settle", busy, 1);
        chk("t1_valid_early", res_valid, 0);
        tick();
        chk("t1_valid", res_valid, 1);
        chk("t1_busy_hold", busy, 1);
        tick();
        chk("t1_hold_y", res_y, 8'h93);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_valid_clr", res_valid, 0);
        chk("t1_busy_idle", busy, 0);
        // fill with consumer stalled
        push_try(4'h9, 4'hB, 3'd1, acc);
        push_try(4'h9, 4'h7, 3'd2, acc);
        push_try(4'hD, 4'hB, 3'd3, acc);
        push_try(4'hB, 4'h7, 3'd4, acc);
        chk("t2_count3", fifo_count, 3);
        chk("t2_valid", res_valid, 1);
        chk("t2_y", res_y, 8'h9B);
        repeat (2) tick();
        chk("t2_y_stable", res_y, 8'h9B);
        chk("t2_s_stable", res_s, 1);
        res_ready = 1'b1;
        push_try(4'h1, 4'h2, 3'd5, acc);
        res_ready = 1'b0;
        chk("t2_pushpop_count", fifo_count, 3);
        push_try(4'h3, 4'h4, 3'd6, acc);
        chk("t2_full_count", fifo_count, 4);
        chk("t2_full_ready", cmd_ready, 0);
        push_try(4'hF, 4'hF, 3'd7, acc);
        chk("t2_refused", acc, 0);
        chk("t2_count_after_refuse", fifo_count, 4);
        gap_en = 1'b1;
        res_ready = 1'b1;
        wait_drain();
        repeat (6) tick();
        gap_en = 1'b0;
        // pointer wrap with random commands
        for (int i = 0; i < 10; i++)
            push_wait(4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)));
        wait_drain();
        push_wait(4'h0, 4'h0, 3'd2);
        push_wait(4'h5, 4'hB, 3'd3);
        wait_drain();
        repeat (4) tick();
        // SETTLE=3 latency
        cmd_a = 4'hE; cmd_b = 4'h7; cmd_s = 3'd6; cmd_valid3 = 1'b1;
        tick();
        cmd_valid3 = 1'b0;
        chk("t4_count", fifo_count3, 1);
        tick();
        chk("t4_alu_a", alu_a3, 4'hE);
        chk("t4_busy", busy3, 1);
        repeat (2) tick();
        chk("t4_valid_early", res_valid3, 0);
        tick();
        chk("t4_valid", res_valid3, 1);
        chk("t4_y", res_y3, 8'hE7);
        chk("t4_s", res_s3, 6);
`ifdef ALU_SEQ_ZFLAG_EN
        chk("t4_zero", res_zero3, 0);
`endif
        res_ready3 = 1'b1;
        tick();
        res_ready3 = 1'b0;
        chk("t4_valid_clr", res_valid3, 0);
        // reset mid-SETTLE with two queued
        cmd_valid3 = 1'b1;
        cmd_a = 4'h1; cmd_b = 4'h2; tick();
        cmd_a = 4'h3; cmd_b = 4'h4; tick();
        cmd_a = 4'h5; cmd_b = 4'h6; tick();
        cmd_valid3 = 1'b0;
        chk("t5_count", fifo_count3, 2);
        chk("t5_busy", busy3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_alu_a", alu_a3, 0);
        chk("t5_count0", fifo_count3, 0);
        chk("t5_busy0", busy3, 0);
        chk("t5_res_y", res_y3, 0);
        chk("t5_res_valid", res_valid3, 0);
        chk("t5_main_res_y", res_y, 0);
        @(negedge clk) rst_n = 1'b1;
        res_ready3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_result", res_valid3, 0);
        end
        chk("t5_count_post", fifo_count3, 0);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
